mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Parametrised N-master arbiter in front of the main memory port of the CPU system.
- Lets several requesters (CPU cores, cache controllers, UART/DMA engines) share one memory port with read_enable/write_enable/ready semantics.
- Supports round-robin or fixed-priority arbitration, per-master completion and error reporting, and a bus-timeout watchdog.
- One transaction is outstanding at a time.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 16, address width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 256, number of BUSY cycles without mem_ready before abort. 0 disables the watchdog.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_reset  input  1  asynchronous, active-low reset.
- m_req  input  NUM_MASTERS  per-master request.
- m_write  input  NUM_MASTERS  per-master direction (1 = write).
- m_addr  input  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wdata  input  NUM_MASTERS*DATA_WIDTH  flattened write data, same slicing.
- m_rdata  output  DATA_WIDTH  shared read-data return.
- m_grant  output  NUM_MASTERS  one-hot owner of the current transaction.
- m_done  output  NUM_MASTERS  one-cycle completion pulse.
- m_err  output  NUM_MASTERS  one-cycle timeout pulse.
- mem_addr_out  output  ADDR_WIDTH  memory address.
- mem_data_out  output  DATA_WIDTH  memory write data.
- mem_read_en  output  1  memory read strobe.
- mem_write_en  output  1  memory write strobe.
- mem_data_in  input  DATA_WIDTH  memory read data.
- mem_ready  input  1  memory completion.

Behaviour:
- Reset (sys_reset low, async) values:
  - state = IDLE.
  - All outputs 0; m_rdata = 0.
  - RR pointer = 0; timeout counter = 0.
  - Deassertion takes effect on the next rising edge.
- FSM states: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If any m_req bit is set at a rising edge, select winner w.
    - ARB_MODE=0: first set bit searching upward from rr_ptr, wrapping from NUM_MASTERS-1 to 0.
    - ARB_MODE=1: lowest set index.
  - On that edge:
    - latch m_write[w], addr slice w and wdata slice w;
    - set m_grant = onehot(w);
    - drive mem_addr_out/mem_data_out;
    - assert mem_read_en = ~m_write[w] or mem_write_en = m_write[w] (exactly one);
    - clear the counter;
    - go to BUSY.
  - If no request, stay in IDLE with strobes 0.
- BUSY:
  - Strobes, address, data and grant stay constant.
  - Request inputs are ignored; a master changing addr/data after grant has no effect.
  - mem_ready=1 sampled at an edge:
    - deassert strobes and m_grant;
    - if the transaction was a read, load m_rdata from mem_data_in (writes leave m_rdata unchanged);
    - pulse m_done[w] for exactly one cycle;
    - rr_ptr = (w+1) mod NUM_MASTERS;
    - go to IDLE.
  - Watchdog (TIMEOUT_CYCLES>0):
    - counter increments each BUSY edge without mem_ready;
    - when the counter reaches TIMEOUT_CYCLES-1 and mem_ready is low: deassert strobes and grant, pulse m_err[w] for one cycle, do not pulse m_done, update rr_ptr as for completion, go to IDLE.
    - If mem_ready is high on that same edge, completion wins (done, no err).
- Latency:
  - Request sampled at edge E0; strobes are visible after E0.
  - Earliest mem_ready sample is at E1, so m_done is high in the cycle after E1.
  - Minimum 2 cycles from request to done.
  - One mandatory IDLE cycle between transactions; peak throughput is one transaction per 3 cycles with zero-wait memory.
- Master contract:
  - Hold m_req, m_write, addr and wdata until its m_done or m_err.
  - Drop m_req in the cycle m_done/m_err is seen, or a new transaction is issued.
  - Dropping m_req before it is granted is legal; that master issues nothing.
- m_rdata holds its value until the next read completion.
- m_done and m_err are never asserted simultaneously and never for more than one master at a time.
- Asynchronous reset mid-BUSY:
  - aborts immediately with all outputs at 0 and no done/err pulse;
  - the memory sees the strobe drop asynchronously.
- Fixed-priority mode may starve high indices; this is by design.

Test Plan:
- Single read, zero wait: master 2 requests a read of addr 0x0040; mem_ready high one cycle after the strobe with data 0xDEADBEEF -> mem_read_en high exactly 1 cycle; m_done = 4'b0100 for one cycle 2 cycles after the request edge; m_rdata = 0xDEADBEEF.
- Round-robin fairness (ARB_MODE=0): all 4 masters hold m_req, with 0-wait memory -> grant order 0,1,2,3,0; each m_done spaced 3 cycles apart.
- Fixed priority (ARB_MODE=1): masters 1 and 3 request continuously, master 1 re-requests after each done -> master 3 is never granted across 10 transactions.
- Write with wait states: master 0 writes 0x12345678 to 0x1FFE; mem_ready delayed 5 cycles -> mem_write_en, address and data stable for 6 cycles; m_done[0] pulses once; m_rdata unchanged.
- Timeout (TIMEOUT_CYCLES=8): mem_ready held low -> strobe deasserts after 8 BUSY cycles; m_err[granted] pulses once with no m_done; the next requester is then served normally. Repeat with mem_ready rising on cycle 8 -> m_done only.
- Reset mid-transaction: sys_reset low during BUSY -> all outputs 0 asynchronously. After release, a new request from master 0 is granted first (rr_ptr reset).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle for mem_arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives requests and models the memory.
interface mem_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
);
  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]            m_grant;
  logic [NUM_MASTERS-1:0]            m_done;
  logic [NUM_MASTERS-1:0]            m_err;
  logic [ADDR_WIDTH-1:0]             mem_addr_out;
  logic [DATA_WIDTH-1:0]             mem_data_out;
  logic                              mem_read_en;
  logic                              mem_write_en;
  logic [DATA_WIDTH-1:0]             mem_data_in;
  logic                              mem_ready;

  modport master (
    output m_req, m_write, m_addr, m_wdata, mem_data_in, mem_ready,
    input  m_rdata, m_grant, m_done, m_err,
           mem_addr_out, mem_data_out, mem_read_en, mem_write_en
  );

  modport slave (
    input  m_req, m_write, m_addr, m_wdata, mem_data_in, mem_ready,
    output m_rdata, m_grant, m_done, m_err,
           mem_addr_out, mem_data_out, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-master arbiter for a single memory port: round-robin or fixed priority,
// one outstanding transaction, per-master done/err pulses and a BUSY watchdog.
module mem_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          sys_clk,
  input logic          sys_reset,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam bit   WDOG_EN  = (TIMEOUT_CYCLES > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rrPtr;
  logic [IDX_W-1:0]        r_owner;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_MASTERS-1:0]  r_grant;
  logic [NUM_MASTERS-1:0]  r_done;
  logic [NUM_MASTERS-1:0]  r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_readEn;
  logic                    r_writeEn;

  logic [IDX_W:0]          w_cand;
  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_winner;
  logic                    w_found;
  logic                    w_cooldown;
  logic [IDX_W-1:0]        w_rrNext;
  logic [NUM_MASTERS-1:0]  w_winHot;

  // Search order starts at the RR pointer (wrapping) or at index 0 in priority mode.
  always_comb begin
    w_cand   = '0;
    w_idx    = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 0) begin
        w_cand = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
        if (w_cand >= (IDX_W+1)'(NUM_MASTERS)) begin
          w_cand = w_cand - (IDX_W+1)'(NUM_MASTERS);
        end
      end else begin
        w_cand = (IDX_W+1)'(k);
      end
      w_idx = w_cand[IDX_W-1:0];
      if (!w_found && bus.m_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // A done/err pulse marks the mandatory idle cycle: the finishing master may still
  // show a stale request here, so arbitration waits one more edge.
  assign w_cooldown = |{r_done, r_err};
  assign w_rrNext   = (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
  assign w_winHot   = NUM_MASTERS'(1) << w_winner;

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_readEn  <= 1'b0;
      r_writeEn <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        IDLE: begin
          if (w_found && !w_cooldown) begin
            r_owner   <= w_winner;
            r_grant   <= w_winHot;
            r_addr    <= bus.m_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata   <= bus.m_wdata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            r_readEn  <= ~bus.m_write[w_winner];
            r_writeEn <= bus.m_write[w_winner];
            r_cnt     <= '0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (r_readEn) begin
              r_rdata <= bus.mem_data_in;
            end
            r_done    <= r_grant;
            r_grant   <= '0;
            r_readEn  <= 1'b0;
            r_writeEn <= 1'b0;
            r_rrPtr   <= w_rrNext;
            r_state   <= IDLE;
          end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
            r_err     <= r_grant;
            r_grant   <= '0;
            r_readEn  <= 1'b0;
            r_writeEn <= 1'b0;
            r_rrPtr   <= w_rrNext;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_rdata      = r_rdata;
  assign bus.m_grant      = r_grant;
  assign bus.m_done       = r_done;
  assign bus.m_err        = r_err;
  assign bus.mem_addr_out = r_addr;
  assign bus.mem_data_out = r_wdata;
  assign bus.mem_read_en  = r_readEn;
  assign bus.mem_write_en = r_writeEn;

endmodule
